// File: rtl/bus_initiator.sv
// 68030-style asynchronous bus initiator.
// Accepts one operand transfer request (1..4 bytes) and splits it into as
// many bus cycles as the responder's dynamically reported port width needs.
// Termination inputs are double-flop synchronized before the FSM uses them.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for REQ; BUSY low
// S_SETUP  | address, size, direction and data enable driven; strobes high
// S_STROBE | nAS asserted (and nDS for reads)
// S_DSW    | write data strobe asserted
// S_WAIT   | waiting for DSACK/BERR or timeout
// S_NEG    | strobes negated, data released
// S_REC    | waiting for responder to release terminations
module bus_initiator #(
  parameter int TIMEOUT_CNT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        REQ,
  input  logic        REQ_RnW,
  input  logic [27:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        nAS,
  output logic        nDS,
  output logic        RnW,
  output logic [1:0]  SIZ,
  output logic [27:0] ADDR,
  output logic [31:0] DOUT,
  output logic        DOE,
  input  logic [31:0] DIN,
  input  logic        nDSACK0,
  input  logic        nDSACK1,
  input  logic        nBERR
);

  localparam int CW = (TIMEOUT_CNT < 2) ? 1 : $clog2(TIMEOUT_CNT + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CNT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_DSW, S_WAIT, S_NEG, S_REC
  } state_t;

  state_t        state_q, state_d;
  logic [27:0]   addr_q, addr_d;
  logic [2:0]    rem_q, rem_d;
  logic          rnw_q, rnw_d;
  logic [31:0]   wsh_q, wsh_d;
  logic [31:0]   racc_q, racc_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [2:0]    nb_q, nb_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          done_q, done_d;
  logic          errp_q, errp_d;

  logic ds0_m, ds0_s, ds1_m, ds1_s, berr_m, berr_s;

  logic [2:0]  port_bytes;
  logic [1:0]  first_lane;
  logic [2:0]  room;
  logic [2:0]  n_calc;
  logic [31:0] racc_shift;
  logic [7:0]  wl [4];
  logic [1:0]  wk;

  // Byte lane L of a 32-bit word; lane 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    lane_byte = w[31:24];
      2'd1:    lane_byte = w[23:16];
      2'd2:    lane_byte = w[15:8];
      default: lane_byte = w[7:0];
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous termination inputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ds0_m  <= 1'b1;
      ds0_s  <= 1'b1;
      ds1_m  <= 1'b1;
      ds1_s  <= 1'b1;
      berr_m <= 1'b1;
      berr_s <= 1'b1;
    end else begin
      ds0_m  <= nDSACK0;
      ds0_s  <= ds0_m;
      ds1_m  <= nDSACK1;
      ds1_s  <= ds1_m;
      berr_m <= nBERR;
      berr_s <= berr_m;
    end
  end

  // Port width from DSACK encoding and bytes this cycle can move.
  always_comb begin
    port_bytes = 3'd1;
    first_lane = 2'd0;
    if (!ds0_s && !ds1_s) begin
      port_bytes = 3'd4;
      first_lane = addr_q[1:0];
    end else if (!ds1_s) begin
      port_bytes = 3'd2;
      first_lane = {1'b0, addr_q[0]};
    end
    room   = port_bytes - {1'b0, first_lane};
    n_calc = (rem_q < room) ? rem_q : room;
  end

  // Append the bytes of this cycle to the read accumulator, MS first.
  always_comb begin
    racc_shift = racc_q;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_calc)
        racc_shift = {racc_shift[23:0], lane_byte(DIN, first_lane + 2'(i))};
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rnw_d   = rnw_q;
    wsh_d   = wsh_q;
    racc_d  = racc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    nb_d    = nb_q;
    wcnt_d  = '0;
    done_d  = 1'b0;
    errp_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          addr_d = REQ_ADDR;
          rnw_d  = REQ_RnW;
          racc_d = '0;
          err_d  = 1'b0;
          // The write operand is kept left-justified so the next byte to
          // send is always bits 31:24.
          case (REQ_SIZE)
            2'b01:   begin rem_d = 3'd1; wsh_d = {REQ_WDATA[7:0], 24'h0}; end
            2'b10:   begin rem_d = 3'd2; wsh_d = {REQ_WDATA[15:0], 16'h0}; end
            2'b11:   begin rem_d = 3'd3; wsh_d = {REQ_WDATA[23:0], 8'h0}; end
            default: begin rem_d = 3'd4; wsh_d = REQ_WDATA; end
          endcase
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = rnw_q ? S_WAIT : S_DSW;
      S_DSW:    state_d = S_WAIT;
      S_WAIT: begin
        wcnt_d = wcnt_q + CW'(1);
        if (!berr_s) begin
          err_d   = 1'b1;
          state_d = S_NEG;
        end else if (!ds0_s || !ds1_s) begin
          nb_d    = n_calc;
          racc_d  = racc_shift;
          state_d = S_NEG;
        end else if (wcnt_q == TC) begin
          err_d   = 1'b1;
          state_d = S_NEG;
        end
      end
      S_NEG: state_d = S_REC;
      S_REC: begin
        if (ds0_s && ds1_s && berr_s) begin
          if (err_q) begin
            errp_d  = 1'b1;
            state_d = S_IDLE;
          end else if (rem_q == nb_q) begin
            done_d  = 1'b1;
            if (rnw_q) rdata_d = racc_q;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + {25'd0, nb_q};
            rem_d   = rem_q - nb_q;
            wsh_d   = wsh_q << {nb_q, 3'b000};
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      rnw_q   <= 1'b1;
      wsh_q   <= '0;
      racc_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      nb_q    <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rnw_q   <= rnw_d;
      wsh_q   <= wsh_d;
      racc_q  <= racc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      nb_q    <= nb_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      errp_q  <= errp_d;
    end
  end

  // Bus control outputs decoded from the current state.
  always_comb begin
    BUSY  = (state_q != S_IDLE);
    nAS   = !(state_q inside {S_STROBE, S_DSW, S_WAIT});
    nDS   = !(((state_q == S_STROBE) && rnw_q) || (state_q inside {S_DSW, S_WAIT}));
    DOE   = !rnw_q && (state_q inside {S_SETUP, S_STROBE, S_DSW, S_WAIT});
    RnW   = (state_q == S_IDLE) ? 1'b1 : rnw_q;
    SIZ   = (state_q == S_IDLE) ? 2'b00 : rem_q[1:0];
    ADDR  = addr_q;
    DONE  = done_q;
    ERR   = errp_q;
    RDATA = rdata_q;
  end

  // Write lane steering: operand bytes from lane A[1:0] upward, lower lanes
  // mirror the upper ones so narrow ports see the same data.
  always_comb begin
    wk = '0;
    for (int l = 0; l < 4; l++) begin
      wl[l] = 8'h00;
      if (2'(l) >= addr_q[1:0]) begin
        wk = 2'(l) - addr_q[1:0];
        if ({1'b0, wk} < rem_q) wl[l] = lane_byte(wsh_q, wk);
      end
    end
    case (addr_q[1:0])
      2'd1: wl[0] = wl[1];
      2'd2: begin wl[0] = wl[2]; wl[1] = wl[3]; end
      2'd3: begin wl[0] = wl[3]; wl[1] = wl[3]; wl[2] = wl[3]; end
      default: ;
    endcase
    DOUT = DOE ? {wl[0], wl[1], wl[2], wl[3]} : 32'h0;
  end

endmodule
